// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared constants and helpers for the 7-segment scan display path:
//   - active-low segment codes {dp,g,f,e,d,c,b,a} for digits 0..9 and blank
//   - active-low one-hot digit selects
//   - conversion FSM state encoding
//   - segment encoder and double-dabble nibble adjust
// ---------------------------------------------------------------------------
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [2:0] SEL_UNITS    = 3'b110;
   localparam logic [2:0] SEL_TENS     = 3'b101;
   localparam logic [2:0] SEL_HUNDREDS = 3'b011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } conv_state_e;

   // Non-decimal nibbles cannot come out of the converter; blank them anyway.
   function automatic logic [7:0] seg_encode(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   // Double-dabble correction applied to each BCD nibble before a shift.
   function automatic logic [3:0] add3_adj(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, 8-bit binary to 3-digit BCD.
// A start pulse in IDLE captures bin; eight SHIFT cycles follow, then one LOAD
// cycle copies the accumulator to bcd in a single update.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a conversion (honoured in IDLE only)
//   bin    in   [7:0] value captured on start
//   bcd    out  [11:0] {hundreds,tens,units}, only ever holds finished results
//   done   out  high during the LOAD cycle (bcd updates at the end of it)
//   busy   out  high while not IDLE
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic [11:0] bcd,
   output logic        done,
   output logic        busy
);

   conv_state_e state_q, state_d;
   logic [7:0]  sh_q, sh_d;
   logic [11:0] acc_q, acc_d;
   logic [11:0] adj;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;

   always_comb begin
      adj = {add3_adj(acc_q[11:8]), add3_adj(acc_q[7:4]), add3_adj(acc_q[3:0])};
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = bin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Hundreds never exceeds 2 for 8-bit input, so adj[11] is always 0.
            acc_d = {adj[10:0], sh_q[7]};
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            bcd_d   = acc_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bcd  = bcd_q;
   assign done = (state_q == LOAD);
   assign busy = (state_q != IDLE);

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Displays an 8-bit value (0..255) as three decimal digits on a multiplexed
// common-anode 7-segment display, with optional leading-zero blanking.
// A change on data_bin (while no conversion is running) launches a BCD
// conversion; the result appears on bcd ten edges after the change is sampled.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   data_bin  in   [7:0] value to display
//   seg       out  [7:0] segments {dp,g,f,e,d,c,b,a}, active-low
//   sel       out  [2:0] digit select, active-low one-hot (bit0 units)
//   bcd       out  [11:0] displayed BCD value {hundreds,tens,units}
//   busy      out  conversion in progress
// Parameters:
//   SCAN_DIV    cycles each digit stays selected (>= 2)
//   BLANK_LEAD  1 blanks leading zeros on hundreds/tens
// ---------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 50000,
   parameter bit          BLANK_LEAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_bin,
   output logic [7:0]  seg,
   output logic [2:0]  sel,
   output logic [11:0] bcd,
   output logic        busy
);

   localparam int unsigned      CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [7:0]       last_q, last_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       seg_q, seg_d;
   logic [2:0]       sel_q, sel_d;
   logic [3:0]       digit;
   logic             blank;

   logic [11:0] conv_bcd;
   logic        conv_done;
   logic        conv_busy;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_q),
      .bin   (last_q),
      .bcd   (conv_bcd),
      .done  (conv_done),
      .busy  (conv_busy)
   );

   // Change detection. busy_q covers the start cycle before the converter
   // leaves IDLE, so a new compare only happens once everything is idle.
   always_comb begin
      start_d = 1'b0;
      last_d  = last_q;
      busy_d  = busy_q;
      if (conv_done) begin
         busy_d = 1'b0;
      end
      if (!busy_q && !conv_busy && (data_bin != last_q)) begin
         start_d = 1'b1;
         last_d  = data_bin;
         busy_d  = 1'b1;
      end
   end

   // Scan counter and digit index run independently of conversions.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
   end

   // seg and sel are both derived from the next index so they switch together.
   always_comb begin
      digit = conv_bcd[3:0];
      blank = 1'b0;
      sel_d = SEL_UNITS;
      unique case (idx_d)
         2'd0: begin
            digit = conv_bcd[3:0];
            blank = 1'b0;
            sel_d = SEL_UNITS;
         end
         2'd1: begin
            digit = conv_bcd[7:4];
            blank = BLANK_LEAD && (conv_bcd[11:4] == 8'h00);
            sel_d = SEL_TENS;
         end
         default: begin
            digit = conv_bcd[11:8];
            blank = BLANK_LEAD && (conv_bcd[11:8] == 4'h0);
            sel_d = SEL_HUNDREDS;
         end
      endcase
      seg_d = blank ? SEG_BLANK : seg_encode(digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         sel_q   <= SEL_UNITS;
      end else begin
         last_q  <= last_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
      end
   end

   assign seg  = seg_q;
   assign sel  = sel_q;
   assign bcd  = conv_bcd;
   assign busy = busy_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b1;
   logic [7:0]  data_bin = 8'd0;
   logic [7:0]  seg, seg_nb;
   logic [2:0]  sel, sel_nb;
   logic [11:0] bcd, bcd_nb;
   logic        busy, busy_nb;

   int n_checks = 0;
   int n_pass   = 0;

   logic [11:0] exp_q[$];
   logic [11:0] prev_bcd = 12'h000;
   logic [11:0] mon_exp;

   always #5 clk = ~clk;

   seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEAD(1'b1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_bin (data_bin),
      .seg      (seg),
      .sel      (sel),
      .bcd      (bcd),
      .busy     (busy)
   );

   seg_scan_driver #(.SCAN_DIV(4), .BLANK_LEAD(1'b0)) dut_nb (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_bin (data_bin),
      .seg      (seg_nb),
      .sel      (sel_nb),
      .bcd      (bcd_nb),
      .busy     (busy_nb)
   );

   // Scoreboard: every change of bcd must be the next queued expected value.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_bcd = 12'h000;
      end else if (bcd !== prev_bcd) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL bcd_unexpected got=%h expected=<none>", bcd);
         end else begin
            mon_exp = exp_q.pop_front();
            if (bcd !== mon_exp) $display("FAIL bcd_sequence got=%h expected=%h", bcd, mon_exp);
            else n_pass++;
         end
         prev_bcd = bcd;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = (exp_q.size() == 0);
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         ok = (exp_q.size() == 0);
      end
   endtask

   task automatic capture(output logic [7:0] u, output logic [7:0] t, output logic [7:0] h,
                          output logic [7:0] nu, output logic [7:0] nt, output logic [7:0] nh);
      u = 8'h00; t = 8'h00; h = 8'h00; nu = 8'h00; nt = 8'h00; nh = 8'h00;
      for (int i = 0; i < 12; i++) begin
         tick();
         case (sel)
            3'b110: begin u = seg; nu = seg_nb; end
            3'b101: begin t = seg; nt = seg_nb; end
            3'b011: begin h = seg; nh = seg_nb; end
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      data_bin = 8'd37;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (seg !== 8'hFF) $display("FAIL rst_seg got=%h expected=ff", seg); else n_pass++;
      n_checks++; if (sel !== 3'b110) $display("FAIL rst_sel got=%b expected=110", sel); else n_pass++;
      n_checks++; if (bcd !== 12'h000) $display("FAIL rst_bcd got=%h expected=000", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b expected=0", busy); else n_pass++;
      #2 rst_n = 1'b1;
      exp_q.push_back(12'h037);
      tick();
      n_checks++; if (seg !== 8'hC0) $display("FAIL first_seg got=%h expected=c0", seg); else n_pass++;
      n_checks++; if (sel !== 3'b110) $display("FAIL first_sel got=%b expected=110", sel); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL first_busy got=%b expected=1", busy); else n_pass++;
      repeat (9) tick();
      n_checks++; if (bcd !== 12'h000) $display("FAIL rst_lat9_bcd got=%h expected=000", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL rst_lat9_busy got=%b expected=1", busy); else n_pass++;
      tick();
      n_checks++; if (bcd !== 12'h037) $display("FAIL rst_lat10_bcd got=%h expected=037", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_lat10_busy got=%b expected=0", busy); else n_pass++;
   endtask

   task automatic test_scan_255();
      bit got;
      int hi;
      logic [2:0] prev_sel;
      logic [2:0] exp_sel;
      logic [7:0] exp_seg;
      data_bin = 8'd255;
      exp_q.push_back(12'h255);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (busy) got = 1'b1;
      end
      n_checks++; if (!got) $display("FAIL busy_rise_255 got=timeout expected=busy"); else n_pass++;
      hi = got ? 1 : 0;
      for (int i = 0; i < 30 && busy; i++) begin
         tick();
         if (busy) hi++;
      end
      n_checks++; if (hi != 10) $display("FAIL busy_len got=%0d expected=10", hi); else n_pass++;
      n_checks++; if (bcd !== 12'h255) $display("FAIL bcd_255 got=%h expected=255", bcd); else n_pass++;
      got = 1'b0;
      prev_sel = sel;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (sel == 3'b110 && prev_sel != 3'b110) got = 1'b1;
         prev_sel = sel;
      end
      n_checks++; if (!got) $display("FAIL scan_align got=timeout expected=sel110"); else n_pass++;
      for (int j = 0; j < 13; j++) begin
         if (j > 0) tick();
         if (j < 4)       begin exp_sel = 3'b110; exp_seg = 8'h92; end
         else if (j < 8)  begin exp_sel = 3'b101; exp_seg = 8'h92; end
         else if (j < 12) begin exp_sel = 3'b011; exp_seg = 8'hA4; end
         else             begin exp_sel = 3'b110; exp_seg = seg; end
         n_checks++;
         if (sel !== exp_sel) $display("FAIL scan_sel[%0d] got=%b expected=%b", j, sel, exp_sel);
         else n_pass++;
         if (j < 12) begin
            n_checks++;
            if (seg !== exp_seg) $display("FAIL scan_seg[%0d] got=%h expected=%h", j, seg, exp_seg);
            else n_pass++;
         end
      end
   endtask

   task automatic test_blank(input logic [7:0] val, input logic [11:0] exp_bcd,
                             input logic [7:0] eu, input logic [7:0] et, input logic [7:0] eh,
                             input logic [7:0] enu, input logic [7:0] ent, input logic [7:0] enh);
      bit ok;
      logic [7:0] u, t, h, nu, nt, nh;
      data_bin = val;
      exp_q.push_back(exp_bcd);
      wait_drain(40, ok);
      n_checks++; if (!ok) $display("FAIL drain_%0d got=timeout expected=bcd %h", val, exp_bcd);
      else n_pass++;
      tick();
      tick();
      capture(u, t, h, nu, nt, nh);
      n_checks++; if (u !== eu) $display("FAIL blank%0d_u got=%h expected=%h", val, u, eu); else n_pass++;
      n_checks++; if (t !== et) $display("FAIL blank%0d_t got=%h expected=%h", val, t, et); else n_pass++;
      n_checks++; if (h !== eh) $display("FAIL blank%0d_h got=%h expected=%h", val, h, eh); else n_pass++;
      n_checks++; if (nu !== enu) $display("FAIL noblank%0d_u got=%h expected=%h", val, nu, enu);
      else n_pass++;
      n_checks++; if (nt !== ent) $display("FAIL noblank%0d_t got=%h expected=%h", val, nt, ent);
      else n_pass++;
      n_checks++; if (nh !== enh) $display("FAIL noblank%0d_h got=%h expected=%h", val, nh, enh);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int  pulses;
      int  since_rise;
      bit  changed;
      logic prev_busy;
      int  busy_seen;
      data_bin = 8'd12;
      exp_q.push_back(12'h012);
      pulses     = 0;
      since_rise = -1;
      changed    = 1'b0;
      prev_busy  = busy;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (busy && !prev_busy) begin
            pulses++;
            if (pulses == 1) since_rise = 0;
         end else if (since_rise >= 0) begin
            since_rise++;
         end
         if (since_rise == 3 && !changed) begin
            data_bin = 8'd200;
            exp_q.push_back(12'h200);
            changed  = 1'b1;
         end
         prev_busy = busy;
      end
      n_checks++; if (pulses != 2) $display("FAIL b2b_pulses got=%0d expected=2", pulses); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d expected=0", exp_q.size());
      else n_pass++;
      n_checks++; if (bcd !== 12'h200) $display("FAIL b2b_bcd got=%h expected=200", bcd); else n_pass++;
      busy_seen = 0;
      data_bin  = 8'd200;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) busy_seen++;
      end
      n_checks++; if (busy_seen != 0) $display("FAIL same_val_busy got=%0d expected=0", busy_seen);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit got;
      data_bin = 8'd150;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (busy) got = 1'b1;
      end
      n_checks++; if (!got) $display("FAIL busy_rise_150 got=timeout expected=busy"); else n_pass++;
      repeat (3) tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (seg !== 8'hFF) $display("FAIL mid_seg got=%h expected=ff", seg); else n_pass++;
      n_checks++; if (sel !== 3'b110) $display("FAIL mid_sel got=%b expected=110", sel); else n_pass++;
      n_checks++; if (bcd !== 12'h000) $display("FAIL mid_bcd got=%h expected=000", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b expected=0", busy); else n_pass++;
      @(negedge clk);
      #2 rst_n = 1'b1;
      exp_q.push_back(12'h150);
      repeat (10) tick();
      n_checks++; if (bcd !== 12'h000) $display("FAIL mid_lat9_bcd got=%h expected=000", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL mid_lat9_busy got=%b expected=1", busy); else n_pass++;
      tick();
      n_checks++; if (bcd !== 12'h150) $display("FAIL mid_lat10_bcd got=%h expected=150", bcd); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_lat10_busy got=%b expected=0", busy); else n_pass++;
   endtask

   initial begin
      #1;
      test_reset();
      test_scan_255();
      test_blank(8'd7, 12'h007, 8'hF8, 8'hFF, 8'hFF, 8'hF8, 8'hC0, 8'hC0);
      test_blank(8'd100, 12'h100, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hF9);
      test_blank(8'd0, 12'h000, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hC0);
      test_back_to_back();
      test_reset_mid();
      tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL final_pending got=%0d expected=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
